// File: rtl/fifo_read_stream_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_pkg
//  Description : Shared constants and types for the FIFO36K read-side stream
//                master: buffer depth, pointer width, default data width,
//                occupancy type, sequence-checker seed and a pointer-advance
//                helper for the 3-entry circular buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_rd_pkg;

    localparam int BUF_DEPTH     = 3;
    localparam int PTR_W         = 2;
    localparam int DEFAULT_WIDTH = 36;
    localparam int SEQ_START     = 1;

    // Occupancy 0..BUF_DEPTH
    typedef logic [1:0] occ_t;

    // Circular pointer advance; depth is not a power of two, so wrap 2 -> 0
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

endpackage : fifo_rd_pkg
`default_nettype wire

// File: rtl/fifo_read_stream_rd_skid_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rd_skid_buf
//  Description : 3-entry circular buffer absorbing the FIFO read latency.
//                Push writes at the tail, pop advances the head; both may
//                happen in the same cycle.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                i_push/i_data - write a word at the tail
//                i_pop         - advance the head
//                o_data        - word at the head (0 after reset)
//                o_occ         - number of stored words
//  Revision    : 1.0 - initial release
// ============================================================================
module rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output occ_t             o_occ
);

    logic [WIDTH-1:0] r_mem [BUF_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    occ_t             r_occ;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_head;

    // Guards keep the pointers consistent even if a caller misbehaves
    assign w_push = i_push && (r_occ != occ_t'(BUF_DEPTH));
    assign w_pop  = i_pop  && (r_occ != '0);

    generate
        for (genvar i = 0; i < BUF_DEPTH; i++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_mem[i] <= '0;
                end else if (w_push && (r_wr_ptr == PTR_W'(i))) begin
                    r_mem[i] <= i_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + occ_t'(1);
                2'b01:   r_occ <= r_occ - occ_t'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_comb begin
        w_head = '0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (r_rd_ptr == PTR_W'(i)) begin
                w_head = r_mem[i];
            end
        end
    end

    assign o_data = w_head;
    assign o_occ  = r_occ;

endmodule : rd_skid_buf
`default_nettype wire

// File: rtl/fifo_read_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fifo_read_stream
//  Description : Read-side master for a FIFO36K. Issues RDEN from registered
//                state only, captures RD_DATA one cycle later into a 3-entry
//                buffer and presents it as a valid/ready stream. Optional
//                checker compares accepted words against 1, 2, 3, ...
//  Ports       : RDCLK, RESET        - clock, synchronous active-high reset
//                RDEN, RD_DATA,
//                EMPTY, UNDERFLOW    - FIFO36K read port
//                M_DATA, M_VALID,
//                M_READY             - output stream
//                RD_COUNT            - accepted words (wrapping)
//                UFLOW_ERR           - sticky underflow flag
//                MISMATCH_CNT        - saturating sequence mismatch count
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_read_stream
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int CHECK_SEQ = 0,
    parameter int CNT_W     = 32
) (
    input  logic             RDCLK,
    input  logic             RESET,
    output logic             RDEN,
    input  logic [WIDTH-1:0] RD_DATA,
    input  logic             EMPTY,
    input  logic             UNDERFLOW,
    output logic [WIDTH-1:0] M_DATA,
    output logic             M_VALID,
    input  logic             M_READY,
    output logic [CNT_W-1:0] RD_COUNT,
    output logic             UFLOW_ERR,
    output logic [15:0]      MISMATCH_CNT
);

    occ_t             w_occ;
    logic             r_inflight;
    logic [2:0]       w_pending;
    logic             w_rden;
    logic             w_capture;
    logic             w_pop;
    logic [WIDTH-1:0] w_head;
    logic [CNT_W-1:0] r_rd_count;
    logic             r_uflow_err;

    // Buffered plus in-flight words must leave room for the word being
    // requested now; M_READY is deliberately not part of this decision.
    assign w_pending = {1'b0, w_occ} + {2'b00, r_inflight};
    assign w_rden    = !RESET && !EMPTY && (w_pending < 3'(BUF_DEPTH));

    // A word that arrives alongside UNDERFLOW is not trustworthy
    assign w_capture = r_inflight && !UNDERFLOW;
    assign w_pop     = M_VALID && M_READY;

    rd_skid_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk    (RDCLK),
        .rst    (RESET),
        .i_push (w_capture),
        .i_data (RD_DATA),
        .i_pop  (w_pop),
        .o_data (w_head),
        .o_occ  (w_occ)
    );

    always_ff @(posedge RDCLK) begin
        if (RESET) begin
            r_inflight  <= 1'b0;
            r_rd_count  <= '0;
            r_uflow_err <= 1'b0;
        end else begin
            r_inflight <= w_rden;
            if (w_pop) begin
                r_rd_count <= r_rd_count + CNT_W'(1);
            end
            if (UNDERFLOW) begin
                r_uflow_err <= 1'b1;
            end
        end
    end

    generate
        if (CHECK_SEQ != 0) begin : g_check
            logic [WIDTH-1:0] r_exp;
            logic [15:0]      r_mismatch;

            // Expected value advances on every pop so a single bad word
            // is counted once and does not shift the following ones.
            always_ff @(posedge RDCLK) begin
                if (RESET) begin
                    r_exp      <= WIDTH'(SEQ_START);
                    r_mismatch <= '0;
                end else if (w_pop) begin
                    r_exp <= r_exp + WIDTH'(1);
                    if ((w_head != r_exp) && (r_mismatch != 16'hFFFF)) begin
                        r_mismatch <= r_mismatch + 16'd1;
                    end
                end
            end

            assign MISMATCH_CNT = r_mismatch;
        end else begin : g_no_check
            assign MISMATCH_CNT = '0;
        end
    endgenerate

    assign RDEN      = w_rden;
    assign M_DATA    = w_head;
    assign M_VALID   = (w_occ != '0);
    assign RD_COUNT  = r_rd_count;
    assign UFLOW_ERR = r_uflow_err;

endmodule : fifo_read_stream
`default_nettype wire

// File: tb/tb_fifo_read_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_read_stream
//  Description : Self-checking bench for fifo_read_stream. A behavioural
//                FIFO36K read port feeds the DUT; written words are pushed
//                to a scoreboard queue and popped as the stream accepts them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_read_stream;

    localparam int W = 36;

    logic          clk;
    logic          RESET;
    logic          RDEN;
    logic [W-1:0]  RD_DATA;
    logic          EMPTY;
    logic          UNDERFLOW;
    logic [W-1:0]  M_DATA;
    logic          M_VALID;
    logic          M_READY;
    logic [31:0]   RD_COUNT;
    logic          UFLOW_ERR;
    logic [15:0]   MISMATCH_CNT;

    logic [W-1:0]  fifo [$];
    logic [W-1:0]  sb   [$];

    int            checks   = 0;
    int            failures = 0;

    // Reference for the stream counters and the sequence checker
    int            m_count;
    logic [W-1:0]  m_exp;
    logic [15:0]   m_mm;

    fifo_read_stream #(
        .WIDTH     (W),
        .CHECK_SEQ (1),
        .CNT_W     (32)
    ) dut (
        .RDCLK        (clk),
        .RESET        (RESET),
        .RDEN         (RDEN),
        .RD_DATA      (RD_DATA),
        .EMPTY        (EMPTY),
        .UNDERFLOW    (UNDERFLOW),
        .M_DATA       (M_DATA),
        .M_VALID      (M_VALID),
        .M_READY      (M_READY),
        .RD_COUNT     (RD_COUNT),
        .UFLOW_ERR    (UFLOW_ERR),
        .MISMATCH_CNT (MISMATCH_CNT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO36K read port: data one cycle after RDEN, EMPTY covers reads so far
    always @(posedge clk) begin
        if (RDEN && (fifo.size() > 0)) begin
            RD_DATA <= fifo.pop_front();
        end
        EMPTY <= (fifo.size() == 0);
    end

    task automatic model_reset();
        m_count = 0;
        m_exp   = W'(1);
        m_mm    = 16'd0;
    endtask

    // Advance to the next falling edge, drive M_READY for the coming edge
    // and report whether a word is accepted on that edge.
    task automatic tick(input bit rdy, output bit popped, output logic [W-1:0] d);
        @(negedge clk);
        M_READY = rdy;
        popped  = M_VALID && rdy;
        d       = M_DATA;
        if (popped) begin
            m_count++;
            if ((d !== m_exp) && (m_mm != 16'hFFFF)) m_mm++;
            m_exp = m_exp + W'(1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        RESET     = 1'b1;
        M_READY   = 1'b0;
        UNDERFLOW = 1'b0;
        fifo.delete();
        sb.delete();
        repeat (2) @(negedge clk);
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (RDEN !== 1'b0)       begin failures++; $display("FAIL reset_rden: got %0h expected 0", RDEN); end
        checks++; if (M_VALID !== 1'b0)    begin failures++; $display("FAIL reset_valid: got %0h expected 0", M_VALID); end
        checks++; if (M_DATA !== '0)       begin failures++; $display("FAIL reset_data: got %0h expected 0", M_DATA); end
        checks++; if (RD_COUNT !== '0)     begin failures++; $display("FAIL reset_count: got %0h expected 0", RD_COUNT); end
        checks++; if (UFLOW_ERR !== 1'b0)  begin failures++; $display("FAIL reset_uflow: got %0h expected 0", UFLOW_ERR); end
        checks++; if (MISMATCH_CNT !== '0) begin failures++; $display("FAIL reset_mism: got %0h expected 0", MISMATCH_CNT); end
    endtask

    task automatic test_stream();
        bit p; logic [W-1:0] d; logic [W-1:0] e; int n; int gaps;
        do_reset();
        for (int i = 1; i <= 1024; i++) begin fifo.push_back(W'(i)); sb.push_back(W'(i)); end
        tick(1'b1, p, d);
        checks++; if (RDEN !== 1'b1)    begin failures++; $display("FAIL lat_rden: got %0h expected 1", RDEN); end
        checks++; if (M_VALID !== 1'b0) begin failures++; $display("FAIL lat_valid1: got %0h expected 0", M_VALID); end
        tick(1'b1, p, d);
        checks++; if (M_VALID !== 1'b0) begin failures++; $display("FAIL lat_valid2: got %0h expected 0", M_VALID); end
        n = 0; gaps = 0;
        tick(1'b1, p, d);
        checks++; if (M_VALID !== 1'b1) begin failures++; $display("FAIL lat_valid3: got %0h expected 1", M_VALID); end
        while (sb.size() > 0 && n < 3000) begin
            if (n > 0) tick(1'b1, p, d);
            n++;
            if (p) begin
                e = sb.pop_front();
                checks++; if (d !== e) begin failures++; $display("FAIL stream_data: got %0h expected %0h", d, e); end
            end else begin
                gaps++;
            end
        end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL stream_timeout: got %0d left expected 0", sb.size()); end
        checks++; if (gaps != 0)      begin failures++; $display("FAIL stream_gaps: got %0d expected 0", gaps); end
        tick(1'b1, p, d);
        checks++; if (RD_COUNT !== 32'd1024) begin failures++; $display("FAIL stream_count: got %0d expected 1024", RD_COUNT); end
        checks++; if (MISMATCH_CNT !== 16'd0) begin failures++; $display("FAIL stream_mism: got %0d expected 0", MISMATCH_CNT); end
        checks++; if (M_VALID !== 1'b0)       begin failures++; $display("FAIL stream_drained: got %0h expected 0", M_VALID); end
        checks++; if (RDEN !== 1'b0)          begin failures++; $display("FAIL stream_rden_empty: got %0h expected 0", RDEN); end
    endtask

    task automatic test_backpressure();
        bit p; logic [W-1:0] d; logic [W-1:0] e; int n; int gaps; int pulses; int unstable;
        do_reset();
        for (int i = 1; i <= 8; i++) begin fifo.push_back(W'(i)); sb.push_back(W'(i)); end
        pulses = 0; unstable = 0;
        for (int c = 0; c < 8; c++) begin
            tick(1'b0, p, d);
            if (RDEN) pulses++;
            if (M_VALID && (d !== W'(1))) unstable++;
        end
        checks++; if (pulses != 3)      begin failures++; $display("FAIL bp_pulses: got %0d expected 3", pulses); end
        checks++; if (unstable != 0)    begin failures++; $display("FAIL bp_hold: got %0d changes expected 0", unstable); end
        checks++; if (RDEN !== 1'b0)    begin failures++; $display("FAIL bp_rden: got %0h expected 0", RDEN); end
        checks++; if (M_VALID !== 1'b1) begin failures++; $display("FAIL bp_valid: got %0h expected 1", M_VALID); end
        checks++; if (M_DATA !== W'(1)) begin failures++; $display("FAIL bp_data: got %0h expected 1", M_DATA); end
        n = 0; gaps = 0;
        while (sb.size() > 0 && n < 100) begin
            tick(1'b1, p, d); n++;
            if (p) begin
                e = sb.pop_front();
                checks++; if (d !== e) begin failures++; $display("FAIL bp_data_order: got %0h expected %0h", d, e); end
            end else begin
                gaps++;
            end
        end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL bp_timeout: got %0d left expected 0", sb.size()); end
        checks++; if (gaps != 0)      begin failures++; $display("FAIL bp_gaps: got %0d expected 0", gaps); end
    endtask

    task automatic test_random_ready();
        bit p; logic [W-1:0] d; logic [W-1:0] e; int n;
        do_reset();
        for (int i = 1; i <= 1025; i++) begin fifo.push_back(W'(i)); sb.push_back(W'(i)); end
        n = 0;
        while (sb.size() > 0 && n < 10000) begin
            tick(1'($urandom_range(0, 1)), p, d); n++;
            if (p) begin
                e = sb.pop_front();
                checks++; if (d !== e) begin failures++; $display("FAIL rand_data: got %0h expected %0h", d, e); end
            end
        end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL rand_timeout: got %0d left expected 0", sb.size()); end
        tick(1'b0, p, d);
        checks++; if (RD_COUNT !== 32'(m_count)) begin failures++; $display("FAIL rand_count: got %0d expected %0d", RD_COUNT, m_count); end
        checks++; if (RD_COUNT !== 32'd1025)     begin failures++; $display("FAIL rand_total: got %0d expected 1025", RD_COUNT); end
        checks++; if (MISMATCH_CNT !== 16'd0)    begin failures++; $display("FAIL rand_mism: got %0d expected 0", MISMATCH_CNT); end
    endtask

    task automatic test_corrupt();
        bit p; logic [W-1:0] d; logic [W-1:0] e; int n;
        do_reset();
        for (int i = 1; i <= 600; i++) begin
            e = (i == 500) ? '0 : W'(i);
            fifo.push_back(e); sb.push_back(e);
        end
        n = 0;
        while (sb.size() > 0 && n < 2000) begin
            tick(1'b1, p, d); n++;
            if (p) begin
                e = sb.pop_front();
                if (m_count == 501) begin
                    checks++; if (MISMATCH_CNT !== 16'd1) begin failures++; $display("FAIL corrupt_at501: got %0d expected 1", MISMATCH_CNT); end
                end
                checks++; if (d !== e) begin failures++; $display("FAIL corrupt_data: got %0h expected %0h", d, e); end
            end
        end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL corrupt_timeout: got %0d left expected 0", sb.size()); end
        tick(1'b0, p, d);
        checks++; if (MISMATCH_CNT !== 16'd1)  begin failures++; $display("FAIL corrupt_mism: got %0d expected 1", MISMATCH_CNT); end
        checks++; if (MISMATCH_CNT !== m_mm)   begin failures++; $display("FAIL corrupt_model: got %0d expected %0d", MISMATCH_CNT, m_mm); end
        checks++; if (RD_COUNT !== 32'd600)    begin failures++; $display("FAIL corrupt_count: got %0d expected 600", RD_COUNT); end
    endtask

    task automatic test_underflow();
        bit p; logic [W-1:0] d; logic [W-1:0] e; int n;
        do_reset();
        for (int i = 1; i <= 4; i++) fifo.push_back(W'(i));
        for (int i = 2; i <= 4; i++) sb.push_back(W'(i));
        tick(1'b0, p, d);
        tick(1'b0, p, d);
        UNDERFLOW = 1'b1;                 // word 1 is on RD_DATA this cycle
        tick(1'b0, p, d);
        UNDERFLOW = 1'b0;
        checks++; if (UFLOW_ERR !== 1'b1) begin failures++; $display("FAIL uflow_set: got %0h expected 1", UFLOW_ERR); end
        n = 0;
        while (sb.size() > 0 && n < 50) begin
            tick(1'b1, p, d); n++;
            if (p) begin
                e = sb.pop_front();
                checks++; if (d !== e) begin failures++; $display("FAIL uflow_data: got %0h expected %0h", d, e); end
            end
        end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL uflow_timeout: got %0d left expected 0", sb.size()); end
        repeat (5) tick(1'b1, p, d);
        checks++; if (UFLOW_ERR !== 1'b1)        begin failures++; $display("FAIL uflow_sticky: got %0h expected 1", UFLOW_ERR); end
        checks++; if (RD_COUNT !== 32'(m_count)) begin failures++; $display("FAIL uflow_count: got %0d expected %0d", RD_COUNT, m_count); end
        checks++; if (MISMATCH_CNT !== m_mm)     begin failures++; $display("FAIL uflow_mism: got %0d expected %0d", MISMATCH_CNT, m_mm); end
        do_reset();
        checks++; if (UFLOW_ERR !== 1'b0) begin failures++; $display("FAIL uflow_clear: got %0h expected 0", UFLOW_ERR); end
    endtask

    task automatic test_reset_mid();
        bit p; logic [W-1:0] d; logic [W-1:0] e; int n; int stale;
        do_reset();
        for (int i = 1; i <= 10; i++) fifo.push_back(W'(i));
        repeat (4) tick(1'b0, p, d);      // now occ=2, inflight=1
        checks++; if (M_VALID !== 1'b1 || M_DATA !== W'(1)) begin failures++; $display("FAIL mid_pre: got valid %0h data %0h expected 1 1", M_VALID, M_DATA); end
        RESET = 1'b1;
        fifo.delete();
        @(negedge clk);
        checks++; if (RDEN !== 1'b0)        begin failures++; $display("FAIL mid_rden: got %0h expected 0", RDEN); end
        checks++; if (M_VALID !== 1'b0)     begin failures++; $display("FAIL mid_valid: got %0h expected 0", M_VALID); end
        checks++; if (M_DATA !== '0)        begin failures++; $display("FAIL mid_data: got %0h expected 0", M_DATA); end
        checks++; if (RD_COUNT !== '0)      begin failures++; $display("FAIL mid_count: got %0h expected 0", RD_COUNT); end
        checks++; if (MISMATCH_CNT !== '0)  begin failures++; $display("FAIL mid_mism: got %0h expected 0", MISMATCH_CNT); end
        RESET = 1'b0;
        model_reset();
        stale = 0;
        repeat (3) begin
            tick(1'b1, p, d);
            if (M_VALID) stale++;
        end
        checks++; if (stale != 0) begin failures++; $display("FAIL mid_stale: got %0d valid cycles expected 0", stale); end
        for (int i = 1; i <= 5; i++) begin fifo.push_back(W'(i)); sb.push_back(W'(i)); end
        n = 0;
        while (sb.size() > 0 && n < 50) begin
            tick(1'b1, p, d); n++;
            if (p) begin
                e = sb.pop_front();
                checks++; if (d !== e) begin failures++; $display("FAIL mid_data_after: got %0h expected %0h", d, e); end
            end
        end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL mid_timeout: got %0d left expected 0", sb.size()); end
        tick(1'b0, p, d);
        checks++; if (MISMATCH_CNT !== 16'd0) begin failures++; $display("FAIL mid_exp_restart: got %0d expected 0", MISMATCH_CNT); end
        checks++; if (RD_COUNT !== 32'd5)     begin failures++; $display("FAIL mid_count_after: got %0d expected 5", RD_COUNT); end
    endtask

    initial begin
        RESET     = 1'b1;
        M_READY   = 1'b0;
        UNDERFLOW = 1'b0;
        RD_DATA   = '0;
        EMPTY     = 1'b1;
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_random_ready();
        test_corrupt();
        test_underflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fifo_read_stream
`default_nettype wire
